// File: rtl/d_mem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the
// single-port data memory; owns the data bus direction.
module d_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] d_mem_addr,
  output logic              d_mem_we,
  inout  wire  [DATA_W-1:0] d_mem_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam int CW = 4;
  localparam logic [CW-1:0] WE_END = CW'(RD_LAT);
  localparam logic [CW-1:0] DN_END = CW'(RD_LAT + 1);

  state_t state_q, state_d;
  logic ptr_q, ptr_d;
  logic own_q, own_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic drv_q, drv_d;
  logic opwe_q, opwe_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic win;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    drv_d   = drv_q;
    opwe_d  = opwe_q;
    wdat_d  = wdat_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    win     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          win     = r1_req && (!r0_req || ptr_q);
          own_d   = win;
          ptr_d   = !win;
          addr_d  = win ? r1_addr : r0_addr;
          drv_d   = win ? r1_we : r0_we;
          opwe_d  = win ? r1_we : r0_we;
          wdat_d  = win ? r1_wdata : r0_wdata;
          gnt0_d  = !win;
          gnt1_d  = win;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WE_END) drv_d = 1'b0;
        // trailing cycle: bus released, memory data settled
        if (cnt_q == DN_END) begin
          state_d = IDLE;
          done0_d = !own_q;
          done1_d = own_q;
          if (!opwe_q) begin
            if (own_q) rd1_d = d_mem_data;
            else       rd0_d = d_mem_data;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      own_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      drv_q   <= 1'b0;
      opwe_q  <= 1'b0;
      wdat_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      drv_q   <= drv_d;
      opwe_q  <= opwe_d;
      wdat_q  <= wdat_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign d_mem_data = drv_q ? wdat_q : {DATA_W{1'bz}};
  assign d_mem_addr = addr_q;
  assign d_mem_we   = drv_q;
  assign r0_gnt     = gnt0_q;
  assign r1_gnt     = gnt1_q;
  assign r0_done    = done0_q;
  assign r1_done    = done1_q;
  assign r0_rdata   = rd0_q;
  assign r1_rdata   = rd1_q;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed bench for d_mem_arbiter with a behavioural
// single-port memory on the shared data bus.
module tb_d_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [5:0]  r0_addr = '0;
  logic [63:0] r0_wdata = '0;
  logic        r0_gnt, r0_done;
  logic [63:0] r0_rdata;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [5:0]  r1_addr = '0;
  logic [63:0] r1_wdata = '0;
  logic        r1_gnt, r1_done;
  logic [63:0] r1_rdata;
  logic [5:0]  d_mem_addr;
  logic        d_mem_we;
  wire  [63:0] d_mem_data;

  logic [63:0] mem [64];
  bit          mem_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  d_mem_arbiter #(.ADDR_W(6), .DATA_W(64), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_done(r1_done),
    .r1_rdata(r1_rdata),
    .d_mem_addr(d_mem_addr), .d_mem_we(d_mem_we),
    .d_mem_data(d_mem_data)
  );

  // memory drives the bus whenever the arbiter is not writing
  assign d_mem_data = d_mem_we ? {64{1'bz}} : mem[d_mem_addr];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++)
        mem[i] = 64'h0F0F_0000_0000_0000 + 64'(i);
      mem[5] = 64'h1122334455667788;
      mem_ready = 1'b1;
    end else if (d_mem_we) begin
      mem[d_mem_addr] = d_mem_data;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_ready) begin
      if (d_mem_we)
        chk("bus_drive_x", 64'($isunknown(d_mem_data)), 64'd0);
      else
        chk("bus_release", d_mem_data, mem[d_mem_addr]);
    end
  end

  typedef struct {
    bit          p;
    bit          we;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } vec_t;

  vec_t tv [7];

  task automatic access(input bit p, input bit we,
                        input logic [5:0] a, input logic [63:0] wd);
    if (p) begin
      r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = wd;
    end else begin
      r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = wd;
    end
    @(negedge clk);
    chk("gnt", 64'({r0_gnt, r1_gnt}), p ? 64'd1 : 64'd2);
    chk("addr", 64'(d_mem_addr), 64'(a));
    chk("we_c1", 64'(d_mem_we), 64'(we));
    if (we) chk("wbus_c1", d_mem_data, wd);
    r0_req = 1'b0; r1_req = 1'b0;
    r0_addr = ~a; r1_addr = ~a;
    r0_wdata = ~wd; r1_wdata = ~wd;
    @(negedge clk);
    chk("hold", 64'({d_mem_we, d_mem_addr, r0_gnt, r1_gnt,
                     r0_done, r1_done}), 64'({we, a, 4'b0}));
    if (we) chk("wbus_c2", d_mem_data, wd);
    @(negedge clk);
    chk("release", 64'({d_mem_we, r0_done, r1_done}), 64'd0);
    @(negedge clk);
    chk("done", 64'({r0_done, r1_done}), p ? 64'd1 : 64'd2);
    @(negedge clk);
    chk("done_end", 64'({r0_done, r1_done, r0_gnt, r1_gnt}), 64'd0);
  endtask

  initial begin
    int ng0, ng1, nd0, nd1;
    tv[0] = '{0, 0, 6'h05, 64'h0,
              64'h1122334455667788, 64'h0};
    tv[1] = '{1, 1, 6'h3F, 64'hDEADBEEFCAFEF00D,
              64'h1122334455667788, 64'h0};
    tv[2] = '{1, 0, 6'h3F, 64'h0,
              64'h1122334455667788, 64'hDEADBEEFCAFEF00D};
    tv[3] = '{0, 0, 6'h3F, 64'h0,
              64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D};
    tv[4] = '{0, 1, 6'h00, 64'hA5A5A5A55A5A5A5A,
              64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D};
    tv[5] = '{1, 0, 6'h00, 64'h0,
              64'hDEADBEEFCAFEF00D, 64'hA5A5A5A55A5A5A5A};
    tv[6] = '{0, 0, 6'h00, 64'h0,
              64'hA5A5A5A55A5A5A5A, 64'hA5A5A5A55A5A5A5A};

    repeat (3) @(negedge clk);
    chk("rst_ctl", 64'({r0_gnt, r1_gnt, r0_done, r1_done, d_mem_we}),
        64'd0);
    chk("rst_addr", 64'(d_mem_addr), 64'd0);
    chk("rst_rd0", r0_rdata, 64'd0);
    chk("rst_rd1", r1_rdata, 64'd0);
    chk("rst_bus", d_mem_data, mem[0]);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ctl", 64'({r0_gnt, r1_gnt, d_mem_we}), 64'd0);

    for (int i = 0; i < 7; i++) begin
      access(tv[i].p, tv[i].we, tv[i].addr, tv[i].wdata);
      chk($sformatf("rd0_v%0d", i), r0_rdata, tv[i].exp0);
      chk($sformatf("rd1_v%0d", i), r1_rdata, tv[i].exp1);
    end

    // r1 pulses req for one cycle while r0 is in its access
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 6'h05;
    @(negedge clk);
    chk("wd_gnt0", 64'(r0_gnt), 64'd1);
    r0_req = 1'b0;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 6'h3F;
    @(negedge clk);
    r1_req = 1'b0;
    ng0 = 0; ng1 = 0; nd0 = 0; nd1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ng0 += int'(r0_gnt); ng1 += int'(r1_gnt);
      nd0 += int'(r0_done); nd1 += int'(r1_done);
    end
    chk("wd_ng1", 64'(ng1), 64'd0);
    chk("wd_nd1", 64'(nd1), 64'd0);
    chk("wd_ng0", 64'(ng0), 64'd0);
    chk("wd_nd0", 64'(nd0), 64'd1);
    chk("wd_rd0", r0_rdata, 64'h1122334455667788);

    // reset during the second cycle of a write
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 6'h10;
    r1_wdata = 64'h0BAD_F00D_1234_5678;
    @(negedge clk);
    r1_req = 1'b0;
    @(negedge clk);
    chk("mid_we", 64'(d_mem_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_we", 64'(d_mem_we), 64'd0);
    chk("ar_addr", 64'(d_mem_addr), 64'd0);
    chk("ar_bus", d_mem_data, mem[0]);
    chk("ar_rd1", r1_rdata, 64'd0);
    nd1 = 0;
    repeat (3) begin
      @(negedge clk);
      nd1 += int'(r1_done) + int'(r0_done) + int'(r1_gnt);
    end
    chk("ar_nodone", 64'(nd1), 64'd0);
    rst_n = 1'b1;

    // continuous contention straight out of reset
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 6'h05;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 6'h3F;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("ct_k%0d", k),
          64'({r0_gnt, r1_gnt, r0_done, r1_done}),
          64'({k % 8 == 0, k % 8 == 4, k % 8 == 3, k % 8 == 7}));
      chk($sformatf("ct_a%0d", k), 64'(d_mem_addr),
          (k % 8 < 4) ? 64'h05 : 64'h3F);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("ct_rd0", r0_rdata, 64'h1122334455667788);
    chk("ct_rd1", r1_rdata, 64'hDEADBEEFCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
